// File: rtl/adder_accum_pkg.sv
// Shared types, default widths and the accumulate-add helper for adder_result_accum.
// Defining ADDER_ACC_SIGNED_EN switches acc_add to sign extension and signed overflow.
package adder_accum_pkg;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam int DATA_W_DEF = 32;
  localparam int ACC_W_DEF  = 40;
  localparam int CNT_W_DEF  = 16;

  // Widest operand acc_add handles; the top passes its real widths as arguments.
  localparam int W_MAX = 64;

  function automatic logic msb_at(input logic [W_MAX-1:0] x, input int unsigned pos);
    return |((x >> pos) & W_MAX'(1));
  endfunction

  // Returns {ovf, sum}: sum is acc + ext(data) wrapped to acc_w bits.
  function automatic logic [W_MAX:0] acc_add(
    input logic [W_MAX-1:0] acc,
    input logic [W_MAX-1:0] data,
    input int unsigned      acc_w,
    input int unsigned      data_w
  );
    logic [W_MAX-1:0] acc_mask;
    logic [W_MAX-1:0] data_mask;
    logic [W_MAX-1:0] ext;
    logic [W_MAX-1:0] acc_m;
    logic [W_MAX:0]   full;
    logic [W_MAX-1:0] sum;
    logic             ovf;
    acc_mask  = {W_MAX{1'b1}} >> (W_MAX - acc_w);
    data_mask = {W_MAX{1'b1}} >> (W_MAX - data_w);
    ext       = data & data_mask;
    acc_m     = acc & acc_mask;
`ifdef ADDER_ACC_SIGNED_EN
    if (msb_at(ext, data_w - 1)) begin
      ext = ext | ~data_mask;
    end
    ext  = ext & acc_mask;
    full = {1'b0, acc_m} + {1'b0, ext};
    sum  = full[W_MAX-1:0] & acc_mask;
    ovf  = (msb_at(acc_m, acc_w - 1) == msb_at(ext, acc_w - 1)) &&
           (msb_at(sum, acc_w - 1) != msb_at(acc_m, acc_w - 1));
`else
    full = {1'b0, acc_m} + {1'b0, ext};
    sum  = full[W_MAX-1:0] & acc_mask;
    ovf  = |((full >> acc_w) & (W_MAX+1)'(1));
`endif
    return {ovf, sum};
  endfunction

endpackage

// File: rtl/adder_result_accum.sv
// Sums bursts of adder results and emits one {sum, count, ovf} summary per burst.
// Build option: ADDER_ACC_SIGNED_EN selects signed extension/overflow (same ports).
module adder_result_accum
  import adder_accum_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  // Handshake: a beat moves when valid && ready are both high at posedge clk;
  // valid never waits on ready, and ready here is a registered state output.

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e            state_q;
  logic [ACC_W-1:0]  acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ovf_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [ACC_W-1:0]  out_sum_q;
  logic [CNT_W-1:0]  out_count_q;
  logic              out_ovf_q;

  logic [W_MAX:0]    add_res;
  logic [ACC_W-1:0]  sum_d;
  logic              ovf_d;
  logic [CNT_W-1:0]  cnt_d;
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = out_valid_q && out_ready;

  always_comb begin
    add_res = acc_add(W_MAX'(acc_q), W_MAX'(in_data), ACC_W, DATA_W);
    sum_d   = add_res[ACC_W-1:0];
    ovf_d   = ovf_q | add_res[W_MAX];
    // The count saturates rather than wraps and never feeds the overflow flag.
    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  end

  if (ACC_W < W_MAX) begin : g_pad
    logic pad_unused;
    assign pad_unused = ^add_res[W_MAX-1:ACC_W];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (in_fire) begin
            if (in_last) begin
              out_sum_q   <= sum_d;
              out_count_q <= cnt_d;
              out_ovf_q   <= ovf_d;
              acc_q       <= '0;
              cnt_q       <= '0;
              ovf_q       <= 1'b0;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= ST_HOLD;
            end else begin
              acc_q <= sum_d;
              cnt_q <= cnt_d;
              ovf_q <= ovf_d;
            end
          end
        end
        ST_HOLD: begin
          // Ready returns only after the summary leaves: no same-cycle turnaround.
          if (out_fire) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            state_q     <= ST_ACC;
          end
        end
        default: begin
          state_q <= ST_ACC;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: doc/adder_result_accum.md
Name: adder_result_accum

Overview:
- Downstream stage of the 32-bit combinational adder.
- Consumes a stream of adder results (adder outx) grouped into bursts, each burst terminated by a last flag.
- Sums every result in the burst into a wider accumulator.
- Emits one summary beat per burst (sum, beat count, overflow flag) over a valid/ready handshake toward the result sink or bench monitor.

Parameters:
- DATA_W, 32, width of in_data; matches adder outx.
- ACC_W, 40, accumulator and out_sum width; must be >= DATA_W.
- CNT_W, 16, beat counter width.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data/in_last valid this cycle.
- in_ready  output  1  block accepts an input beat this cycle.
- in_data  input  DATA_W  adder result.
- in_last  input  1  final beat of the current burst.
- out_valid  output  1  summary beat valid.
- out_ready  input  1  sink accepts the summary.
- out_sum  output  ACC_W  burst sum.
- out_count  output  CNT_W  beats in the burst.
- out_ovf  output  1  accumulator overflowed during the burst.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Reset values:
  - State = ACC.
  - acc = 0, cnt = 0, ovf = 0.
  - out_valid = 0, out_sum = 0, out_count = 0, out_ovf = 0.
  - in_ready = 1 immediately after reset deasserts.
- Input accept: a beat is accepted when in_valid && in_ready at posedge. Output accept: when out_valid && out_ready at posedge.
- FSM, two states, encoding in package:
  - ACC:
    - in_ready = 1, out_valid = 0.
    - Accepted beat, non-last: acc <= acc + ext(in_data); cnt <= cnt + 1; ovf |= carry/overflow of that add.
    - Accepted beat with in_last: out_sum <= acc + ext(in_data); out_count <= cnt + 1; out_ovf <= ovf | overflow of this add. Then clear acc, cnt, ovf and go to HOLD.
  - HOLD:
    - in_ready = 0, out_valid = 1; output registers are stable.
    - Output accepted -> ACC next cycle.
    - in_ready stays 0 during the accept cycle (no same-cycle turnaround).
- Latency:
  - Summary valid the cycle after the last beat is accepted.
  - Minimum two cycles between consecutive bursts' last beats.
- Arithmetic:
  - Default ext() is zero-extension to ACC_W.
  - Sum wraps mod 2^ACC_W.
  - Overflow = carry out of bit ACC_W-1.
  - ovf is sticky for the burst.
- Count: saturates at 2^CNT_W-1 and does not wrap; saturation does not set out_ovf.
- Single-beat burst (in_last on first beat): out_sum = ext(in_data), out_count = 1.
- in_valid low in ACC: no state change. Gaps inside a burst are allowed.
- in_data/in_last changes while in HOLD: ignored.
- out_ready held low: HOLD persists indefinitely and upstream is back-pressured.
- Reset mid-burst or in HOLD: partial accumulation and pending summary are discarded; all reset values apply asynchronously.
- out_* fields are only meaningful while out_valid = 1, but they hold their last value after the handshake.

Optional Feature:
- ADDER_ACC_SIGNED_EN defined:
  - ext() sign-extends in_data.
  - Overflow = signed overflow of the ACC_W add (operand signs equal, result sign differs).
- Undefined: unsigned zero-extension and carry-out overflow as above.
- Port list is identical in both builds.

Decomposition:
- Package adder_accum_pkg holds:
  - state enum (ST_ACC, ST_HOLD);
  - default widths DATA_W_DEF = 32, ACC_W_DEF = 40, CNT_W_DEF = 16;
  - a function acc_add(acc, data) returning {ovf, sum}, implementing ext() under the macro.
- No sub-module; the datapath is a single adder plus registers.

Test Plan:
- Burst of 5 and 2 (the adder's 5+2 = 7 fed as beats 7, then 3 with last) -> out_valid next cycle, out_sum = 10, out_count = 2, out_ovf = 0.
- Single beat 0xFFFFFFFF with last -> out_sum = 0x00FFFFFFFF, out_count = 1, out_ovf = 0 (unsigned build).
- 257 beats of 0xFFFFFFFF, last on beat 257 -> out_sum = 257*0xFFFFFFFF mod 2^40 = 0x00FFFFFEFF, out_ovf = 1.
- out_ready held low 10 cycles after summary -> in_ready = 0 and outputs stable throughout; out_ready = 1 -> handshake, in_ready = 1 on the following cycle.
- Reset asserted asynchronously after 3 beats (1, 2, 3) -> out_valid = 0 immediately; new burst 4 with last -> out_sum = 4, out_count = 1.
- Signed build (ADDER_ACC_SIGNED_EN): beats 0xFFFFFFFF, then 0x00000002 with last -> out_sum = 1, out_ovf = 0.
